uart_tx_buf: RTL
================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..4095.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit between the data bits and the stop bit.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-006 data  input  8  byte to transmit; sampled only on an accepted load.
REQ-007 load  input  1  write strobe; accepted when load=1 and ready=1 at a rising edge.
REQ-008 ready  output  1  1 = one-entry holding register is empty and can accept a byte.
REQ-009 tx  output  1  serial line, idle high, registered output.
REQ-010 busy  output  1  1 = FSM is outside IDLE.
REQ-011 done  output  1  one-cycle pulse marking the end of each frame's stop bit.

Function
REQ-012 Frame format: start bit 0; data[0] first through data[7]; optional parity bit; one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-013 Storage: one 8-bit holding register plus a full flag, and one 8-bit shift register; ready = ~full.
REQ-014 Accepted load: at the accepting edge, holding <= data and full <= 1.
REQ-015 A load with ready=0 is ignored; holding contents and tx are unchanged.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: tx=1, busy=0; when full=1, the next edge moves holding into the shifter, clears full, enters START and drives tx=0.
REQ-018 Load latency: tx falls at the edge after the accepting edge when the FSM is in IDLE.
REQ-019 Bit timing: a baud counter counts 0..CLKS_PER_BIT-1 per bit; the bit advances on the terminal count, and the counter resets to 0 on every state entry.
REQ-020 START -> DATA after CLKS_PER_BIT cycles.
REQ-021 DATA: a 3-bit index counts 0..7; after bit 7 the FSM goes to PARITY if PARITY_EN=1, else to STOP.
REQ-022 Parity bit value: XOR of the 8 data bits, XORed with PARITY_OKD=PARITY_ODD.
REQ-023 Parity is computed from the byte latched into the shifter, not from the live data input.
REQ-024 STOP: tx=1; done=1 during the last cycle of the stop bit.
REQ-025 STOP exit with full=1: go directly to START (back-to-back frames, no idle cycles between stop and start), transferring holding to the shifter on the same edge.
REQ-026 STOP exit with full=0: go to IDLE.
REQ-027 Loading during a frame: ready is 1 while the holding register is empty, so a load is accepted mid-frame and does not disturb the frame in progress.
REQ-028 Simultaneous transfer and load: at the transfer edge, ready=0 (full=1), so no load can collide with the transfer; full drops to 0 after that edge.
REQ-029 busy = 1 in START, DATA, PARITY and STOP.

Reset
REQ-030 While reset=1: tx=1, ready=1, busy=0, done=0, FSM=IDLE, full=0, counters=0, holding and shifter=0.
REQ-031 Reset asserted mid-frame aborts the frame immediately (tx returns high asynchronously) and discards any held byte.
REQ-032 After reset deasserts, the first accepted load starts a normal frame with the latency of REQ-018.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-033 Load 0xA5 in IDLE -> tx falls one edge later; samples at bit centres read 0,1,0,1,0,0,1,0,1,1; done pulses once at cycle 40; busy=1 for exactly 40 cycles.
REQ-034 Load 0x3C, then load 0xC3 during frame 1 -> ready drops to 0 after the second load; frame 2 start bit follows the stop bit with no gap; two done pulses 40 cycles apart.
REQ-035 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, frame 44 cycles; with PARITY_ODD=1 -> parity bit 0.
REQ-036 Load asserted while ready=0 with data 0xFF -> ignored; the next transmitted byte is the previously held value.
REQ-037 Reset pulsed during DATA bit 3 -> tx=1, busy=0, ready=1 within the same cycle; no done pulse; a subsequent 0x55 load transmits correctly.
REQ-038 CLKS_PER_BIT=2, 16 back-to-back random bytes -> a scoreboard UART model decodes all 16 bytes in order, with no idle cycles between frames.

Source files
------------

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered 8-bit UART transmitter with optional parity
//
// One-entry holding register in front of a shift register so the next byte
// can be queued while the current frame is on the wire. Frame format is
// start(0), data[0..7], optional parity, stop(1). Each bit lasts
// CLKS_PER_BIT clocks.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous, active-high; clears all state
//   data   - byte to send, sampled only when a load is accepted
//   load   - write strobe, accepted when ready=1 at a rising edge
//   ready  - holding register empty
//   tx     - serial line, idle high, registered
//   busy   - frame in progress (FSM outside IDLE)
//   done   - one-cycle pulse during the last cycle of each stop bit

module uart_tx_buf #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRELAST = CW'(CLKS_PER_BIT - 2);
    localparam logic PEN = (PARITY_EN != 0);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state;
    logic [CW-1:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  holding;
    logic [7:0]  shifter;
    logic        full;
    logic        baud_end;
    logic        parity_bit;

    assign baud_end   = (baud == BAUD_LAST);
    // Parity comes from the latched byte so later loads cannot affect it.
    assign parity_bit = (^shifter) ^ ODD;
    assign ready      = ~full;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            holding <= 8'd0;
            shifter <= 8'd0;
            full    <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;

            // Transfers below only happen with full=1, so they never
            // coincide with an accepted load.
            if (load && !full) begin
                holding <= data;
                full    <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (full) begin
                        shifter <= holding;
                        full    <= 1'b0;
                        state   <= S_START;
                        tx      <= 1'b0;
                    end
                end

                S_START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                        tx      <= shifter[0];
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                S_DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PEN) begin
                                state <= S_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shifter[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                S_STOP: begin
                    // done is registered, so raise it one cycle early to
                    // land on the final cycle of the stop bit.
                    if (baud == BAUD_PRELAST) begin
                        done <= 1'b1;
                    end
                    if (baud_end) begin
                        baud <= '0;
                        if (full) begin
                            shifter <= holding;
                            full    <= 1'b0;
                            state   <= S_START;
                            tx      <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule
